// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for the pipelined adder-subtractor.
interface pipelined_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Z;
   logic             N;
   logic             V;
   modport master (
      output in_valid, A, B, Cin, op, out_ready,
      input  in_ready, out_valid, Sum, Cout, Z, N, V
   );
   modport slave (
      input  in_valid, A, B, Cin, op, out_ready,
      output in_ready, out_valid, Sum, Cout, Z, N, V
   );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: add / subtract-with-borrow split into STAGES ripple chunks, one chunk per stage.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input logic               clk,
   input logic               rst,
   pipelined_addsub_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;
   logic             adv;
   logic [WIDTH-1:0] a_s [STAGES];
   logic [WIDTH-1:0] b_s [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             c_s [STAGES];
   logic             v_s [STAGES];
   logic [WIDTH-1:0] r_d [STAGES];
   logic [CHUNK:0]   part_d [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] r_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, z_q, n_q, ov_q;
   assign adv = !out_valid_q || bus.out_ready;
   // Subtract is folded in at entry: B is inverted and the borrow becomes carry-in !Cin.
   always_comb begin
      a_s[0] = bus.A;
      b_s[0] = bus.op ? ~bus.B : bus.B;
      c_s[0] = bus.Cin ^ bus.op;
      r_s[0] = '0;
      v_s[0] = bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_s[k] = a_q[k-1];
         b_s[k] = b_q[k-1];
         c_s[k] = c_q[k-1];
         r_s[k] = r_q[k-1];
         v_s[k] = v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part_d[k] = {1'b0, a_s[k][k*CHUNK +: CHUNK]} + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_s[k]};
         r_d[k] = r_s[k];
         r_d[k][k*CHUNK +: CHUNK] = part_d[k][CHUNK-1:0];
      end
   end
   // The last stage lands directly in the output registers together with its flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES - 1; k++) v_q[k] <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         ov_q        <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < STAGES - 1; k++) begin
            v_q[k] <= v_s[k];
            a_q[k] <= a_s[k];
            b_q[k] <= b_s[k];
            r_q[k] <= r_d[k];
            c_q[k] <= part_d[k][CHUNK];
         end
         out_valid_q <= v_s[STAGES-1];
         sum_q       <= r_d[STAGES-1];
         cout_q      <= part_d[STAGES-1][CHUNK];
         z_q         <= ~|r_d[STAGES-1];
         n_q         <= r_d[STAGES-1][WIDTH-1];
         ov_q        <= (a_s[STAGES-1][WIDTH-1] == b_s[STAGES-1][WIDTH-1])
                     && (r_d[STAGES-1][WIDTH-1] != a_s[STAGES-1][WIDTH-1]);
      end
   end
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.Sum       = sum_q;
   assign bus.Cout      = cout_q;
   assign bus.Z         = z_q;
   assign bus.N         = n_q;
   assign bus.V         = ov_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors on STAGES=1, 4 and 8 instances fed the same operand stream.
module tb_pipelined_addsub;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        op = 1'b0;
   logic        out_ready = 1'b1;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] sum_w [3];
   logic [3:0]  flg_w [3];
   logic        ov_w [3];
   logic        rdy_w [3];
   pipelined_addsub_if #(.WIDTH(32)) if1 ();
   pipelined_addsub_if #(.WIDTH(32)) if4 ();
   pipelined_addsub_if #(.WIDTH(32)) if8 ();
   pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
   pipelined_addsub #(.WIDTH(32), .STAGES(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   assign if1.in_valid = in_valid;
   assign if1.A = a;
   assign if1.B = b;
   assign if1.Cin = cin;
   assign if1.op = op;
   assign if1.out_ready = out_ready;
   assign if4.in_valid = in_valid;
   assign if4.A = a;
   assign if4.B = b;
   assign if4.Cin = cin;
   assign if4.op = op;
   assign if4.out_ready = out_ready;
   assign if8.in_valid = in_valid;
   assign if8.A = a;
   assign if8.B = b;
   assign if8.Cin = cin;
   assign if8.op = op;
   assign if8.out_ready = out_ready;
   assign sum_w[0] = if1.Sum;
   assign sum_w[1] = if4.Sum;
   assign sum_w[2] = if8.Sum;
   assign flg_w[0] = {if1.Cout, if1.Z, if1.N, if1.V};
   assign flg_w[1] = {if4.Cout, if4.Z, if4.N, if4.V};
   assign flg_w[2] = {if8.Cout, if8.Z, if8.N, if8.V};
   assign ov_w[0] = if1.out_valid;
   assign ov_w[1] = if4.out_valid;
   assign ov_w[2] = if8.out_valid;
   assign rdy_w[0] = if1.in_ready;
   assign rdy_w[1] = if4.in_ready;
   assign rdy_w[2] = if8.in_ready;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   // flags packed as {Cout, Z, N, V}; latency after the capture edge is STAGES-1 further edges
   task automatic beat(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tc, input logic to, input logic [31:0] esum, input logic [3:0] eflg);
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      a = ta;
      b = tb;
      cin = tc;
      op = to;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int e = 0; e < 8; e++) begin
         if (e > 0) begin
            @(posedge clk);
            #1;
         end
         for (int j = 0; j < 3; j++) begin
            lat = (j == 0) ? 0 : (j == 1) ? 3 : 7;
            chk($sformatf("%s_valid_s%0d_e%0d", tag, j, e), ov_w[j], e == lat);
            if (e == lat) begin
               chk($sformatf("%s_sum_s%0d", tag, j), sum_w[j], esum);
               chk($sformatf("%s_flags_s%0d", tag, j), flg_w[j], eflg);
            end
         end
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      int sent, got, seen;
      logic [31:0] held;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("rst_valid_s%0d", j), ov_w[j], 0);
         chk($sformatf("rst_sum_s%0d", j), sum_w[j], 0);
         chk($sformatf("rst_flags_s%0d", j), flg_w[j], 0);
         chk($sformatf("rst_ready_s%0d", j), rdy_w[j], 1);
      end
      beat("add_fill",  32'hff000f0f, 32'h00fff0f0, 1'b0, 1'b0, 32'hffffffff, 4'b0010);
      beat("add_ovf",   32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b0011);
      beat("add_wrap",  32'hffffffff, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 4'b1100);
      beat("add_cin",   32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000003, 4'b0000);
      beat("add_chunk", 32'h000000ff, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 4'b0000);
      beat("sub_eq",    32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 4'b1100);
      beat("sub_neg",   32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hffffffff, 4'b0010);
      beat("sub_ovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7fffffff, 4'b1001);
      beat("sub_brw",   32'h00000005, 32'h00000002, 1'b1, 1'b1, 32'h00000002, 4'b1000);
      sent = 0;
      got = 0;
      held = '0;
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 5 && c < 8);
         in_valid = sent < 6;
         a = sent;
         b = 10 * sent;
         cin = 1'b0;
         op = 1'b0;
         #1;
         if (c >= 5 && c < 8) begin
            chk($sformatf("stall_valid_c%0d", c), ov_w[1], 1);
            chk($sformatf("stall_ready_c%0d", c), rdy_w[1], 0);
            if (c == 5) held = sum_w[1];
            else chk($sformatf("stall_hold_c%0d", c), sum_w[1], held);
         end
         if (ov_w[1] && out_ready) begin
            chk($sformatf("seq%0d", got), sum_w[1], 11 * got);
            got++;
         end
         if (in_valid && rdy_w[1]) sent++;
         @(posedge clk);
         #1;
      end
      chk("stream_sent", sent, 6);
      chk("stream_got", got, 6);
      out_ready = 1'b0;
      op = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         a = 100 + c;
         b = '0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_stalled", ov_w[1], 1);
      rst = 1'b1;
      in_valid = 1'b1;
      a = 32'h999;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
         chk($sformatf("flush_valid_s%0d", j), ov_w[j], 0);
         chk($sformatf("flush_sum_s%0d", j), sum_w[j], 0);
         chk($sformatf("flush_flags_s%0d", j), flg_w[j], 0);
         chk($sformatf("flush_ready_s%0d", j), rdy_w[j], 1);
      end
      out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         for (int j = 0; j < 3; j++) if (ov_w[j]) seen++;
      end
      chk("flush_ghosts", seen, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
